// File: rtl/branch_resolver_if.sv
// Resolution request/result, prediction lookup and statistics bundle for branch_resolver.
interface branch_resolver_if #(
    parameter int unsigned WORD_LEN = 32,
    parameter int unsigned PC_LEN   = 32,
    parameter int unsigned CNT_W    = 16
);
    logic [PC_LEN-1:0]   lookup_pc;
    logic                lookup_taken;
    logic                valid_in;
    logic [PC_LEN-1:0]   pc_in;
    logic [WORD_LEN-1:0] reg1;
    logic [WORD_LEN-1:0] reg2;
    logic [2:0]          cond;
    logic                pred_taken;
    logic                stall;
    logic                stat_clr;
    logic                res_valid;
    logic                br_cond;
    logic                mispredict;
    logic                flush;
    logic [CNT_W-1:0]    branch_cnt;
    logic [CNT_W-1:0]    mispred_cnt;

    modport master (
        output lookup_pc, valid_in, pc_in, reg1, reg2, cond, pred_taken, stall, stat_clr,
        input  lookup_taken, res_valid, br_cond, mispredict, flush, branch_cnt, mispred_cnt
    );

    modport slave (
        input  lookup_pc, valid_in, pc_in, reg1, reg2, cond, pred_taken, stall, stat_clr,
        output lookup_taken, res_valid, br_cond, mispredict, flush, branch_cnt, mispred_cnt
    );
endinterface

// File: rtl/branch_resolver.sv
// Branch resolution stage: condition evaluation, 2-bit saturating-counter predictor,
// registered outcome/mispredict flags and saturating branch statistics.
module branch_resolver #(
    parameter int unsigned WORD_LEN  = 32,
    parameter int unsigned PC_LEN    = 32,
    parameter int unsigned BHT_DEPTH = 16,
    parameter int unsigned CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    branch_resolver_if.slave   bus
);
    localparam int unsigned IDX_W = $clog2(BHT_DEPTH);
    localparam logic [1:0]       CTR_INIT = 2'b01;
    localparam logic [1:0]       CTR_MAX  = 2'b11;
    localparam logic [1:0]       CTR_MIN  = 2'b00;
    localparam logic [CNT_W-1:0] STAT_MAX = '1;

    typedef enum logic [2:0] {
        C_NONE = 3'b000,
        C_JUMP = 3'b001,
        C_BEZ  = 3'b010,
        C_BEQ  = 3'b011,
        C_BNE  = 3'b100,
        C_BLTZ = 3'b101,
        C_BGEZ = 3'b110,
        C_BGTZ = 3'b111
    } cond_e;

    logic [1:0]       bht_q [BHT_DEPTH];
    logic             res_valid_q, br_cond_q, mispredict_q, flush_q;
    logic [CNT_W-1:0] branch_cnt_q, mispred_cnt_q;

    logic [IDX_W-1:0] lookup_idx_c, res_idx_c;
    logic             outcome_c, is_cond_c, resolve_c, mispred_c;
    logic             sign_c, zero_c;
    logic             unused_pc_bits;

    assign lookup_idx_c   = bus.lookup_pc[IDX_W+1:2];
    assign res_idx_c      = bus.pc_in[IDX_W+1:2];
    assign unused_pc_bits = ^{bus.lookup_pc, bus.pc_in};

    assign sign_c    = bus.reg1[WORD_LEN-1];
    assign zero_c    = (bus.reg1 == '0);
    assign is_cond_c = (bus.cond != C_NONE) && (bus.cond != C_JUMP);
    assign resolve_c = bus.valid_in && !bus.stall;
    assign mispred_c = is_cond_c && (outcome_c != bus.pred_taken);

    // Branch condition evaluation on the full operand width
    always_comb begin
        outcome_c = 1'b0;
        unique case (cond_e'(bus.cond))
            C_NONE: outcome_c = 1'b0;
            C_JUMP: outcome_c = 1'b1;
            C_BEZ:  outcome_c = zero_c;
            C_BEQ:  outcome_c = (bus.reg1 == bus.reg2);
            C_BNE:  outcome_c = (bus.reg1 != bus.reg2);
            C_BLTZ: outcome_c = sign_c;
            C_BGEZ: outcome_c = !sign_c;
            C_BGTZ: outcome_c = !sign_c && !zero_c;
            default: outcome_c = 1'b0;
        endcase
    end

    // Result registers; an idle unstalled edge clears them
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_valid_q  <= 1'b0;
            br_cond_q    <= 1'b0;
            mispredict_q <= 1'b0;
            flush_q      <= 1'b0;
        end else if (!bus.stall) begin
            res_valid_q  <= bus.valid_in;
            br_cond_q    <= bus.valid_in && outcome_c;
            mispredict_q <= bus.valid_in && mispred_c;
            flush_q      <= bus.valid_in && mispred_c;
        end
    end

    // Predictor table: only conditional resolutions train it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(BHT_DEPTH); i++) begin
                bht_q[i] <= CTR_INIT;
            end
        end else if (resolve_c && is_cond_c) begin
            if (outcome_c) begin
                if (bht_q[res_idx_c] != CTR_MAX) bht_q[res_idx_c] <= bht_q[res_idx_c] + 2'(1);
            end else begin
                if (bht_q[res_idx_c] != CTR_MIN) bht_q[res_idx_c] <= bht_q[res_idx_c] - 2'(1);
            end
        end
    end

    // Saturating statistics; clear wins over a same-cycle increment
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else if (!bus.stall) begin
            if (bus.stat_clr) begin
                branch_cnt_q  <= '0;
                mispred_cnt_q <= '0;
            end else if (bus.valid_in && is_cond_c) begin
                if (branch_cnt_q != STAT_MAX) branch_cnt_q <= branch_cnt_q + CNT_W'(1);
                if (mispred_c && (mispred_cnt_q != STAT_MAX)) begin
                    mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign bus.lookup_taken = bht_q[lookup_idx_c][1];
    assign bus.res_valid    = res_valid_q;
    assign bus.br_cond      = br_cond_q;
    assign bus.mispredict   = mispredict_q;
    assign bus.flush        = flush_q;
    assign bus.branch_cnt   = branch_cnt_q;
    assign bus.mispred_cnt  = mispred_cnt_q;
endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed literal checks plus randomized
// traffic compared every cycle against a behavioural predictor/statistics model.
module tb_branch_resolver;
    localparam int CNT_MAX = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   chk_on = 1'b0;
    int   checks = 0;
    int   fails  = 0;

    branch_resolver_if #(.WORD_LEN(32), .PC_LEN(32), .CNT_W(4)) bus ();

    branch_resolver #(.WORD_LEN(32), .PC_LEN(32), .BHT_DEPTH(16), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural reference state
    int m_tab [16];
    int m_bcnt, m_mcnt;
    bit m_res, m_br, m_mis;

    function automatic bit outcome(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            3'd0: return 1'b0;
            3'd1: return 1'b1;
            3'd2: return a == 0;
            3'd3: return a == b;
            3'd4: return a != b;
            3'd5: return $signed(a) < 0;
            3'd6: return $signed(a) >= 0;
            default: return $signed(a) > 0;
        endcase
    endfunction

    task automatic model_reset();
        foreach (m_tab[i]) m_tab[i] = 1;
        m_bcnt = 0; m_mcnt = 0;
        m_res = 0; m_br = 0; m_mis = 0;
    endtask

    initial model_reset();

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            model_reset();
        end else if (!bus.stall) begin
            bit o, cnd;
            int idx;
            o   = outcome(bus.cond, bus.reg1, bus.reg2);
            cnd = bus.cond >= 3'd2;
            idx = int'(bus.pc_in[5:2]);
            m_res = bus.valid_in;
            m_br  = bus.valid_in && o;
            m_mis = bus.valid_in && cnd && (o != bus.pred_taken);
            if (bus.valid_in && cnd) m_tab[idx] = o ? ((m_tab[idx] < 3) ? m_tab[idx] + 1 : 3)
                                                    : ((m_tab[idx] > 0) ? m_tab[idx] - 1 : 0);
            if (bus.stat_clr) begin
                m_bcnt = 0; m_mcnt = 0;
            end else if (bus.valid_in && cnd) begin
                if (m_bcnt < CNT_MAX) m_bcnt++;
                if (m_mis && m_mcnt < CNT_MAX) m_mcnt++;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_on) begin
            chk("res_valid", 32'(bus.res_valid), 32'(m_res));
            chk("br_cond", 32'(bus.br_cond), 32'(m_br));
            chk("mispredict", 32'(bus.mispredict), 32'(m_mis));
            chk("flush", 32'(bus.flush), 32'(m_res && m_mis));
            chk("branch_cnt", 32'(bus.branch_cnt), 32'(m_bcnt));
            chk("mispred_cnt", 32'(bus.mispred_cnt), 32'(m_mcnt));
            chk("lookup_taken", 32'(bus.lookup_taken), 32'(m_tab[int'(bus.lookup_pc[5:2])] >= 2));
        end
    end

    task automatic set_in(input bit v, input logic [31:0] pc, input logic [31:0] r1,
                          input logic [31:0] r2, input logic [2:0] c, input bit pt);
        bus.valid_in = v; bus.pc_in = pc; bus.reg1 = r1; bus.reg2 = r2;
        bus.cond = c; bus.pred_taken = pt; bus.stall = 1'b0; bus.stat_clr = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        set_in(0, 0, 0, 0, 3'd0, 0);
        tick();
        rst = 1'b1;
    endtask

    function automatic logic [31:0] pick_op();
        case ($urandom_range(0, 4))
            0: return 32'h0;
            1: return 32'h5;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    int exp_a [8] = '{0, 1, 0, 1, 0, 1, 0, 0};
    int exp_b [8] = '{0, 1, 1, 0, 1, 0, 1, 0};

    initial begin
        logic [31:0] r1;
        bus.lookup_pc = 32'h123;
        set_in(0, 0, 0, 0, 3'd0, 0);
        #1 rst = 1'b0;
        #1;
        chk("rst_res_valid", 32'(bus.res_valid), 0);
        chk("rst_lookup", 32'(bus.lookup_taken), 0);
        chk("rst_branch_cnt", 32'(bus.branch_cnt), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        chk_on = 1'b1;

        for (int i = 0; i < 8; i++) begin
            set_in(1, 32'h100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'(i), 0);
            tick();
            chk("sweep_ones", 32'(bus.br_cond), 32'(exp_a[i]));
        end
        for (int i = 0; i < 8; i++) begin
            set_in(1, 32'h104, 32'h0, 32'h5, 3'(i), 0);
            tick();
            chk("sweep_zero5", 32'(bus.br_cond), 32'(exp_b[i]));
        end

        // Training one entry, then same-cycle lookup/update
        do_reset();
        bus.lookup_pc = 32'h40;
        #1 chk("pre_train_lookup", 32'(bus.lookup_taken), 0);
        for (int k = 0; k < 4; k++) begin
            set_in(1, 32'h40, 32'h7, 32'h7, 3'd3, 0);
            tick();
            chk("beq_taken", 32'(bus.br_cond), 1);
            chk("beq_mispredict", 32'(bus.mispredict), 1);
            chk("beq_flush", 32'(bus.flush), 1);
            chk("beq_lookup", 32'(bus.lookup_taken), 1);
        end
        set_in(1, 32'h40, 32'h7, 32'h8, 3'd3, 0);
        tick();
        chk("nt_mispredict", 32'(bus.mispredict), 0);
        chk("nt_lookup_10", 32'(bus.lookup_taken), 1);
        set_in(1, 32'h40, 32'h7, 32'h8, 3'd3, 0);
        #1 chk("same_cycle_lookup", 32'(bus.lookup_taken), 1);
        tick();
        chk("after_update_lookup", 32'(bus.lookup_taken), 0);
        chk("branch_cnt_6", 32'(bus.branch_cnt), 6);
        chk("mispred_cnt_4", 32'(bus.mispred_cnt), 4);

        // Stall holds everything for three edges
        set_in(1, 32'h200, 32'h0, 32'h0, 3'd1, 0);
        bus.stall = 1'b1;
        repeat (3) begin
            tick();
            chk("stall_br_cond", 32'(bus.br_cond), 0);
            chk("stall_res_valid", 32'(bus.res_valid), 1);
            chk("stall_branch_cnt", 32'(bus.branch_cnt), 6);
        end
        bus.stall = 1'b0;
        tick();
        chk("unstall_jump", 32'(bus.br_cond), 1);
        chk("unstall_cnt", 32'(bus.branch_cnt), 6);

        // Statistics saturation and clear priority
        repeat (20) begin
            set_in(1, 32'h80, 32'h3, 32'h3, 3'd4, 1);
            tick();
        end
        chk("sat_branch_cnt", 32'(bus.branch_cnt), 15);
        chk("sat_mispred_cnt", 32'(bus.mispred_cnt), 15);
        set_in(1, 32'h80, 32'h3, 32'h3, 3'd4, 1);
        bus.stat_clr = 1'b1;
        tick();
        chk("clr_branch_cnt", 32'(bus.branch_cnt), 0);
        chk("clr_mispred_cnt", 32'(bus.mispred_cnt), 0);
        chk("clr_keeps_mispredict", 32'(bus.mispredict), 1);
        set_in(0, 32'h80, 32'h0, 32'h0, 3'd1, 0);
        tick();
        chk("idle_res_valid", 32'(bus.res_valid), 0);
        chk("idle_br_cond", 32'(bus.br_cond), 0);

        // Randomized traffic with a mid-stream asynchronous reset
        for (int n = 0; n < 1500; n++) begin
            r1 = pick_op();
            set_in($urandom_range(0, 9) < 8, {$urandom_range(0, 255), 2'b00}, r1,
                   ($urandom_range(0, 1) == 1) ? r1 : pick_op(), 3'($urandom_range(0, 7)),
                   1'($urandom_range(0, 1)));
            bus.lookup_pc = {$urandom_range(0, 255), 2'b00};
            bus.stall = ($urandom_range(0, 9) == 0);
            bus.stat_clr = !bus.stall && ($urandom_range(0, 49) == 0);
            tick();
            if (n == 700) begin
                #2 rst = 1'b0;
                #1;
                chk("async_res_valid", 32'(bus.res_valid), 0);
                chk("async_mispredict", 32'(bus.mispredict), 0);
                chk("async_flush", 32'(bus.flush), 0);
                chk("async_branch_cnt", 32'(bus.branch_cnt), 0);
                chk("async_mispred_cnt", 32'(bus.mispred_cnt), 0);
                chk("async_lookup", 32'(bus.lookup_taken), 0);
                tick();
                rst = 1'b1;
            end
        end

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
